// File: rtl/tqvp_edge_counter_multi.sv
// Multi-channel edge counter for the TinyQV peripheral bus. It counts rising, falling or both edges
// per channel into wrapping or saturating counters, which software reads through snapshot registers.
module tqvp_edge_counter_multi #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    localparam int B = CNT_W / 8;
    localparam logic [15:0] MODE_MASK = 16'((32'd1 << (2 * NUM_CH)) - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]  cnt_q  [NUM_CH];
    logic [CNT_W-1:0]  cnt_d  [NUM_CH];
    logic [CNT_W-1:0]  snap_q [NUM_CH];
    logic [CNT_W-1:0]  snap_d [NUM_CH];
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic [NUM_CH-1:0] prev_q;
    logic [NUM_CH-1:0] hit;
    logic [15:0]       mode_q, mode_d;
    logic [1:0]        ctrl_q, ctrl_d;

    logic wr_mode_lo, wr_mode_hi, wr_clear, wr_ovf, wr_ctrl, wr_snap;

    assign wr_mode_lo = data_write && (address == 4'h8);
    assign wr_mode_hi = data_write && (address == 4'h9);
    assign wr_clear   = data_write && (address == 4'hA);
    assign wr_ovf     = data_write && (address == 4'hB);
    assign wr_ctrl    = data_write && (address == 4'hC);
    assign wr_snap    = data_write && (address == 4'hE);

    // Mode bit 0 selects rising edges and bit 1 selects falling edges, so 11 counts both.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i] = ctrl_q[0] &
                     ((mode_q[2*i]   &  ui_in[i] & ~prev_q[i]) |
                      (mode_q[2*i+1] & ~ui_in[i] &  prev_q[i]));
        end
    end

    always_comb begin
        mode_d = mode_q;
        ctrl_d = ctrl_q;
        ovf_d  = ovf_q;
        if (wr_mode_lo) mode_d[7:0]  = data_in & MODE_MASK[7:0];
        if (wr_mode_hi) mode_d[15:8] = data_in & MODE_MASK[15:8];
        if (wr_ctrl)    ctrl_d       = data_in[1:0];
        if (wr_ovf)     ovf_d        = ovf_q & ~data_in[NUM_CH-1:0];
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]  = cnt_q[i];
            snap_d[i] = snap_q[i];
            if (wr_snap && data_in[i]) snap_d[i] = cnt_q[i];
            // A clear drops a coincident edge. An overflow set overrides a coincident W1C.
            if (wr_clear && data_in[i]) begin
                cnt_d[i] = '0;
            end else if (hit[i]) begin
                if (&cnt_q[i]) begin
                    ovf_d[i] = 1'b1;
                    if (!ctrl_q[1]) cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // prev_q tracks the input during reset too, so a level held through reset is not an edge.
    always_ff @(posedge clk) begin
        prev_q <= ui_in[NUM_CH-1:0];
        if (!rst_n) begin
            mode_q <= '0;
            ctrl_q <= '0;
            ovf_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= '0;
                snap_q[i] <= '0;
            end
        end else begin
            mode_q <= mode_d;
            ctrl_q <= ctrl_d;
            ovf_q  <= ovf_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                snap_q[i] <= snap_d[i];
            end
        end
    end

    always_comb begin
        data_out = '0;
        case (address)
            4'h8: data_out = mode_q[7:0];
            4'h9: data_out = mode_q[15:8];
            4'hB: data_out[NUM_CH-1:0] = ovf_q;
            4'hC: data_out = {6'b0, ctrl_q};
            4'hD: data_out = ui_in;
            default: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    for (int k = 0; k < B; k++) begin
                        if (address == 4'(i * B + k)) data_out = snap_q[i][8*k +: 8];
                    end
                end
            end
        endcase
    end

    always_comb begin
        uo_out = '0;
        uo_out[NUM_CH-1:0] = ovf_q;
    end

endmodule

// File: doc/tqvp_edge_counter_multi.md
Name: tqvp_edge_counter_multi

Overview:
Multi-channel edge counter peripheral for the TinyQV peripheral bus. Each of NUM_CH channels watches one ui_in bit and counts rising, falling or both edges into a CNT_W-bit counter, selectable per channel. Counters can be wrapped or saturated, and report overflow flags. They are read through software-triggered snapshot registers, so multi-byte values are coherent.

Parameters:
NUM_CH, 4, number of channels (1..8); channel i watches ui_in[i]
CNT_W, 16, counter width, 8 or 16; requires NUM_CH*(CNT_W/8) <= 8

Ports:
clk  input  1  clock; TinyQV project clock (64 MHz nominal)
rst_n  input  1  reset, synchronous, active-low
ui_in  input  8  input PMOD, already synchronised upstream; bit i feeds channel i
uo_out  output  8  bit i = ovf[i] for i<NUM_CH, other bits 0
address  input  4  register address within peripheral
data_write  input  1  write strobe, data_in valid when high
data_in  input  8  write data
data_out  output  8  read data, combinational from address

Behaviour:
- Address map (B = CNT_W/8). Snapshot byte k of channel i is at address i*B+k, little-endian, read-only; writes to 0x0-0x7 are ignored. Addresses in 0x0-0x7 beyond NUM_CH*B read 0.
- 0x8 MODE_LO (R/W): 2 bits per channel for ch0-3, bits[2i+1:2i]. 0x9 MODE_HI (R/W): same for ch4-7. Mode 00=off, 01=rising, 10=falling, 11=both. Bits for unimplemented channels read 0.
- 0xA CLEAR (write-only, reads 0): each 1 bit zeroes that live counter on the next clock edge.
- 0xB OVF (R, write-1-to-clear): sticky overflow flags.
- 0xC CTRL (R/W): bit0 EN (global count enable), bit1 SAT (1=saturate, 0=wrap). Bits[7:2] read 0.
- 0xD reads raw ui_in. 0xE SNAP (write-only, reads 0): each 1 bit copies that live counter into its snapshot register. 0xF reads 0.
- Reset: all counters, snapshots, OVF, MODE and CTRL are 0. uo_out=0. prev_i is loaded with ui_in[i] during reset, so an input held high through reset does not count.
- Edge detect: prev_i <= ui_in[i] every cycle, regardless of EN or mode.
  - rise = ui_in[i] & ~prev_i; fall = ~ui_in[i] & prev_i; hit selected by mode.
  - Counter increments on the same clock edge that updates prev_i.
  - Latency: ui_in change sampled at edge n means the counter is +1 after edge n.
- Counting occurs only when EN=1 and mode != 00. Changing the mode never creates a spurious count.
- Wrap (SAT=0): on increment at all-ones, counter becomes 0 and ovf[i] is set.
- Saturate (SAT=1): on increment at all-ones, counter holds all-ones and ovf[i] is set.
- Simultaneous events, same cycle:
  - CLEAR and hit: clear wins, counter = 0, edge lost, ovf unaffected.
  - SNAP and hit: snapshot captures the pre-increment value; live counter still increments.
  - SNAP and CLEAR on the same channel: never in the same write (different addresses), so not applicable.
  - OVF W1C and new overflow: set wins, flag stays 1.
- Snapshot registers change only on a SNAP write or reset. Live counters are not directly readable.
- Reset asserted mid-count returns all state to reset values at the next clock edge.

Test Plan:
- Reset with ui_in=0xFF held, release, MODE_LO=0x55, CTRL=1, hold 10 cycles, SNAP=0x0F -> all snapshots read 0; no rise counted from reset state.
- MODE_LO=0x03 (ch0 both), CTRL=1, 5 full pulses on ui_in[0], SNAP=0x01 -> addr0=0x0A, addr1=0x00; other channels 0.
- Ch1 rising, wrap mode: drive 65537 rising edges, SNAP=0x02 -> addr2=0x01, addr3=0x00, OVF=0x02, uo_out[1]=1. Write OVF=0x02 -> OVF=0x00.
- Ch2 falling, SAT=1: drive 65540 falling edges, SNAP -> addr4=0xFF, addr5=0xFF, OVF bit2=1. A further edge leaves the value at 0xFFFF.
- CLEAR=0x08 in the same cycle as a ch3 rising edge with count 7 -> live count 0. SNAP in the same cycle as an edge with count 4 -> snapshot 4; a later SNAP reads 5.
- EN=0 with 3 rising edges on ch0, then EN=1 -> count unchanged; no spurious count on enable.
